// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue ID->REG sequencing controller.
// Decides dual / single / stall per cycle, tracks long-latency destinations
// in a scoreboard and holds off issue for a fixed gap after privileged ops.
// Optional performance counters: define ISSUE_PERF_CNT_EN.
module issue_scheduler #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned PRIV_GAP = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [1:0] in_mask,
  output logic       in_allowin,
  input  logic [4:0] rd0,
  input  logic [4:0] rj0,
  input  logic [4:0] rk0,
  input  logic [4:0] rd1,
  input  logic [4:0] rj1,
  input  logic [4:0] rk1,
  input  logic       we0,
  input  logic       we1,
  input  logic       is_alu0,
  input  logic       is_alu1,
  input  logic       is_long0,
  input  logic       is_long1,
  input  logic       is_priv0,
  input  logic       is_priv1,
  input  logic       out_allowin,
  output logic [1:0] issue_valid,
  output logic       issue_swap,
  input  logic [1:0] wb_valid,
  input  logic [4:0] wb_rd0,
  input  logic [4:0] wb_rd1,
  output logic       busy
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {PAIR, SECOND, GAP} state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [NREG-1:0]   set_v, clr_v;
  logic              hz0, hz1, dual_ok, second_c;

  function automatic logic [NREG-1:0] onehot(input logic [REG_W-1:0] r);
    return NREG'(1) << r;
  endfunction

  // Scoreboard bit to set when a long op writing a real register issues.
  function automatic logic [NREG-1:0] lset(input logic lng, input logic we,
                                           input logic [REG_W-1:0] rd);
    return (lng && we && (rd != '0)) ? onehot(rd) : '0;
  endfunction

  function automatic logic hz(input logic [REG_W-1:0] rj, input logic [REG_W-1:0] rk,
                              input logic [NREG-1:0] sb);
    return ((rj != '0) && sb[rj]) || ((rk != '0) && sb[rk]);
  endfunction

  assign hz0 = hz(rj0, rk0, sb_q);
  assign hz1 = hz(rj1, rk1, sb_q);

  // Both halves can leave together only as independent simple ALU ops.
  assign dual_ok = (in_mask == 2'b11) && is_alu0 && is_alu1 && !is_priv0 && !is_priv1 && !hz1
                && !(we0 && (rd0 != '0) && ((rd0 == rj1) || (rd0 == rk1)))
                && !(we0 && we1 && (rd0 == rd1));

  // Slot0 carries inst1: the pending half of a split pair, or a pair whose inst0 is already gone.
  assign second_c = (state_q == SECOND) || ((state_q == PAIR) && (in_mask == 2'b10));

  assign busy = (state_q != PAIR);

  // Issue decision, next state, scoreboard update; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    set_v       = '0;
    clr_v       = '0;
    issue_valid = 2'b00;
    issue_swap  = 1'b0;
    in_allowin  = 1'b0;

    if (wb_valid[0]) clr_v = clr_v | onehot(wb_rd0);
    if (wb_valid[1]) clr_v = clr_v | onehot(wb_rd1);

    if (in_valid && second_c) begin
      issue_swap = 1'b1;
      if (!hz1) begin
        issue_valid = 2'b01;
        if (out_allowin) begin
          in_allowin = 1'b1;
          set_v      = lset(is_long1, we1, rd1);
          pend_d     = 1'b0;
          if (is_priv1) begin
            state_d = GAP;
            cnt_d   = GAP_W'(PRIV_GAP);
          end else begin
            state_d = PAIR;
          end
        end
      end
    end else begin
      case (state_q)
        PAIR: begin
          if (in_valid) begin
            if (in_mask[0]) begin
              if (!hz0) begin
                if (dual_ok) begin
                  issue_valid = 2'b11;
                  in_allowin  = out_allowin;
                  if (out_allowin) set_v = lset(is_long0, we0, rd0) | lset(is_long1, we1, rd1);
                end else begin
                  issue_valid = 2'b01;
                  in_allowin  = out_allowin && !in_mask[1];
                  if (out_allowin) begin
                    set_v = lset(is_long0, we0, rd0);
                    if (is_priv0) begin
                      state_d = GAP;
                      cnt_d   = GAP_W'(PRIV_GAP);
                      pend_d  = in_mask[1];
                    end else if (in_mask[1]) begin
                      state_d = SECOND;
                    end
                  end
                end
              end
            end else begin
              in_allowin = out_allowin;
            end
          end
        end
        SECOND: ;
        GAP: begin
          if (cnt_q <= GAP_W'(1)) begin
            state_d = pend_q ? SECOND : PAIR;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - GAP_W'(1);
          end
        end
        default: state_d = PAIR;
      endcase
    end

    sb_d = (sb_q & ~clr_v) | set_v;

    if (flush) begin
      state_d     = PAIR;
      cnt_d       = '0;
      pend_d      = 1'b0;
      sb_d        = '0;
      issue_valid = 2'b00;
      issue_swap  = 1'b0;
      in_allowin  = 1'b0;
    end

    if (!rstn) begin
      issue_valid = 2'b00;
      issue_swap  = 1'b0;
      in_allowin  = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PAIR;
      sb_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] dual_cnt_q, dual_cnt_d;
  logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Event counters; free-running and untouched by flush.
  always_comb begin
    dual_cnt_d   = dual_cnt_q;
    single_cnt_d = single_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if ((issue_valid == 2'b11) && out_allowin) dual_cnt_d = dual_cnt_q + CNT_W'(1);
    if ((issue_valid == 2'b01) && out_allowin) single_cnt_d = single_cnt_q + CNT_W'(1);
    if (in_valid && (issue_valid == 2'b00) && (state_q != GAP)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dual_cnt_q   <= '0;
      single_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      dual_cnt_q   <= dual_cnt_d;
      single_cnt_q <= single_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign dual_cnt   = dual_cnt_q;
  assign single_cnt = single_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed scenarios with literal expectations,
// then randomized pair traffic checked each cycle against a behavioural model.
module tb_issue_scheduler;

  localparam int unsigned G = 2;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rj;
    logic [4:0] rk;
    logic       we;
    logic       alu;
    logic       lng;
    logic       priv;
  } inst_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_allowin = 1'b1;
  logic [1:0] in_mask = 2'b00;
  logic [1:0] wb_valid = 2'b00;
  logic [4:0] wb_rd0 = '0;
  logic [4:0] wb_rd1 = '0;
  inst_t      i0 = '0;
  inst_t      i1 = '0;
  logic       in_allowin, issue_swap, busy;
  logic [1:0] issue_valid;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] dual_cnt, single_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  issue_scheduler #(.NREG(32), .PRIV_GAP(G), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_mask(in_mask),
    .in_allowin(in_allowin),
    .rd0(i0.rd), .rj0(i0.rj), .rk0(i0.rk), .rd1(i1.rd), .rj1(i1.rj), .rk1(i1.rk),
    .we0(i0.we), .we1(i1.we), .is_alu0(i0.alu), .is_alu1(i1.alu),
    .is_long0(i0.lng), .is_long1(i1.lng), .is_priv0(i0.priv), .is_priv1(i1.priv),
    .out_allowin(out_allowin), .issue_valid(issue_valid), .issue_swap(issue_swap),
    .wb_valid(wb_valid), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .busy(busy)
`ifdef ISSUE_PERF_CNT_EN
    , .dual_cnt(dual_cnt), .single_cnt(single_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: scoreboard as a bit set, remaining gap cycles, split-pair bookkeeping.
  logic [31:0] m_sb, n_sb;
  int          m_gap, n_gap;
  bit          m_gts, n_gts, m_second, n_second;
  int unsigned m_dual, m_single, m_stall, n_dual, n_single, n_stall;
  logic [1:0]  e_iv;
  bit          e_ia, e_sw, e_busy;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic inst_t mk(input int rd, input int rj, input int rk, input bit we,
                               input bit alu, input bit lng, input bit priv);
    inst_t x;
    x.rd = 5'(rd); x.rj = 5'(rj); x.rk = 5'(rk);
    x.we = we; x.alu = alu; x.lng = lng; x.priv = priv;
    return x;
  endfunction

  function automatic bit mhz(input inst_t x);
    return ((x.rj != 0) && m_sb[x.rj]) || ((x.rk != 0) && m_sb[x.rk]);
  endfunction

  function automatic logic [31:0] mset(input inst_t x);
    logic [31:0] v = '0;
    if (x.lng && x.we && (x.rd != 0)) v[x.rd] = 1'b1;
    return v;
  endfunction

  task automatic mreset();
    m_sb = '0; m_gap = 0; m_gts = 0; m_second = 0;
    m_dual = 0; m_single = 0; m_stall = 0;
  endtask

  // Sample at negedge: derive expected outputs from the rules, compare, compute next model state.
  task automatic eval();
    bit in_gap, sec, dual, fire;
    int gap_len;
    @(negedge clk);
    gap_len = (G == 0) ? 1 : int'(G);
    in_gap  = (m_gap > 0);
    sec     = !in_gap && in_valid && (m_second || (in_mask == 2'b10));
    dual    = (in_mask == 2'b11) && i0.alu && i1.alu && !i0.priv && !i1.priv && !mhz(i1)
           && !(i0.we && (i0.rd != 0) && ((i0.rd == i1.rj) || (i0.rd == i1.rk)))
           && !(i0.we && i1.we && (i0.rd == i1.rd));
    e_iv = 2'b00; e_ia = 0; e_sw = 0;
    if (rstn && !flush && !in_gap && in_valid) begin
      if (sec) begin
        e_sw = 1;
        if (!mhz(i1)) e_iv = 2'b01;
        e_ia = (e_iv != 0) && out_allowin;
      end else if (in_mask[0] && !mhz(i0)) begin
        if (dual) begin e_iv = 2'b11; e_ia = out_allowin; end
        else begin e_iv = 2'b01; e_ia = out_allowin && !in_mask[1]; end
      end
    end
    e_busy = rstn && (m_second || in_gap);
    chk("issue_valid", int'(issue_valid), int'(e_iv));
    chk("in_allowin", int'(in_allowin), int'(e_ia));
    chk("issue_swap", int'(issue_swap), int'(e_sw));
    chk("busy", int'(busy), int'(e_busy));
`ifdef ISSUE_PERF_CNT_EN
    chk("dual_cnt", int'(dual_cnt), int'(m_dual));
    chk("single_cnt", int'(single_cnt), int'(m_single));
    chk("stall_cnt", int'(stall_cnt), int'(m_stall));
`endif
    fire = (e_iv != 0) && out_allowin;
    n_sb = m_sb; n_gap = m_gap; n_gts = m_gts; n_second = m_second;
    n_dual = m_dual + ((fire && e_iv == 2'b11) ? 1 : 0);
    n_single = m_single + ((fire && e_iv == 2'b01) ? 1 : 0);
    n_stall = m_stall + ((in_valid && e_iv == 2'b00 && !in_gap) ? 1 : 0);
    if (wb_valid[0]) n_sb[wb_rd0] = 1'b0;
    if (wb_valid[1]) n_sb[wb_rd1] = 1'b0;
    if (fire) begin
      if (sec) n_sb = n_sb | mset(i1);
      else begin
        n_sb = n_sb | mset(i0);
        if (e_iv == 2'b11) n_sb = n_sb | mset(i1);
      end
    end
    if (in_gap) begin
      n_gap = m_gap - 1;
      if (n_gap == 0) begin n_second = m_gts; n_gts = 0; end
    end else if (fire) begin
      if (sec) begin
        n_second = 0;
        if (i1.priv) begin n_gap = gap_len; n_gts = 0; end
      end else if (e_iv == 2'b01) begin
        if (i0.priv) begin n_gap = gap_len; n_gts = in_mask[1]; end
        else if (in_mask[1]) n_second = 1;
      end
    end
    if (flush) begin n_sb = '0; n_gap = 0; n_gts = 0; n_second = 0; end
    if (!rstn) begin
      n_sb = '0; n_gap = 0; n_gts = 0; n_second = 0; n_dual = 0; n_single = 0; n_stall = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    m_sb = n_sb; m_gap = n_gap; m_gts = n_gts; m_second = n_second;
    m_dual = n_dual; m_single = n_single; m_stall = n_stall;
  endtask

  task automatic go(input inst_t a, input inst_t b, input logic [1:0] m);
    i0 = a; i1 = b; in_mask = m; in_valid = 1'b1;
  endtask

  inst_t add_a, add_b, raw_b, ldi, csr;
  bit    have;

  initial begin
    mreset();
    add_a = mk(1, 2, 3, 1, 1, 0, 0);
    add_b = mk(4, 5, 6, 1, 1, 0, 0);
    raw_b = mk(7, 1, 2, 1, 1, 0, 0);
    csr   = mk(0, 0, 0, 0, 0, 0, 1);

    // Reset with a valid pair presented: nothing leaves.
    go(add_a, add_b, 2'b11);
    eval();
    chk("rst_iv", int'(issue_valid), 0); chk("rst_ia", int'(in_allowin), 0);
    chk("rst_busy", int'(busy), 0); chk("rst_sw", int'(issue_swap), 0);
    adv();
    rstn = 1'b1;

    // Independent ALU pair dual-issues.
    eval();
    chk("dual_iv", int'(issue_valid), 3); chk("dual_sw", int'(issue_swap), 0);
    chk("dual_ia", int'(in_allowin), 1); chk("dual_busy", int'(busy), 0);
    adv();

    // RAW pair splits over two cycles.
    go(add_a, raw_b, 2'b11);
    eval(); chk("raw1_iv", int'(issue_valid), 1); chk("raw1_ia", int'(in_allowin), 0);
    adv();
    eval(); chk("raw2_iv", int'(issue_valid), 1); chk("raw2_sw", int'(issue_swap), 1);
    chk("raw2_ia", int'(in_allowin), 1);
    adv();

    // Load r5 then dependent add stalls until writeback of r5.
    ldi = mk(5, 2, 0, 1, 0, 1, 0);
    go(ldi, '0, 2'b01);
    eval(); chk("ld_iv", int'(issue_valid), 1); adv();
    go(mk(6, 5, 0, 1, 1, 0, 0), '0, 2'b01);
    eval(); chk("ldu1_iv", int'(issue_valid), 0); adv();
    eval(); chk("ldu2_iv", int'(issue_valid), 0); adv();
    wb_valid = 2'b01; wb_rd0 = 5'd5;
    eval(); chk("ldwb_iv", int'(issue_valid), 0); adv();
    wb_valid = 2'b00;
    eval(); chk("ldu3_iv", int'(issue_valid), 1); chk("ldu3_ia", int'(in_allowin), 1); adv();

    // Privileged slot0 with inst1 pending: issue, two idle cycles, then inst1 swapped.
    go(csr, mk(8, 2, 3, 1, 1, 0, 0), 2'b11);
    eval(); chk("csr_iv", int'(issue_valid), 1); chk("csr_ia", int'(in_allowin), 0); adv();
    eval(); chk("gap1_iv", int'(issue_valid), 0); chk("gap1_busy", int'(busy), 1); adv();
    eval(); chk("gap2_iv", int'(issue_valid), 0); chk("gap2_busy", int'(busy), 1); adv();
    eval(); chk("gapx_iv", int'(issue_valid), 1); chk("gapx_sw", int'(issue_swap), 1);
    chk("gapx_ia", int'(in_allowin), 1); adv();
    in_valid = 1'b0;
    eval(); chk("idle_busy", int'(busy), 0); adv();

    // Flush in SECOND clears state and scoreboard.
    go(mk(10, 0, 0, 1, 0, 1, 0), '0, 2'b01);
    eval(); adv();
    go(add_a, raw_b, 2'b11);
    eval(); adv();
    flush = 1'b1;
    eval(); chk("fl_iv", int'(issue_valid), 0); chk("fl_ia", int'(in_allowin), 0); adv();
    flush = 1'b0;
    go(mk(2, 10, 0, 1, 1, 0, 0), '0, 2'b01);
    eval(); chk("flx_busy", int'(busy), 0); chk("flx_iv", int'(issue_valid), 1); adv();

    // Set beats clear on the same index.
    go(mk(9, 0, 0, 1, 0, 1, 0), '0, 2'b01);
    wb_valid = 2'b01; wb_rd0 = 5'd9;
    eval(); chk("sw9_iv", int'(issue_valid), 1); adv();
    wb_valid = 2'b00;
    go(mk(3, 9, 0, 1, 1, 0, 0), '0, 2'b01);
    eval(); chk("sb9_iv", int'(issue_valid), 0); adv();
    wb_valid = 2'b11; wb_rd0 = 5'd9; wb_rd1 = 5'd9;
    eval(); adv();
    wb_valid = 2'b00;
    eval(); chk("sb9c_iv", int'(issue_valid), 1); adv();

    // Async reset mid-GAP.
    go(csr, '0, 2'b01);
    eval(); adv();
    in_valid = 1'b0;
    eval(); chk("mg_busy", int'(busy), 1); adv();
    go(add_a, add_b, 2'b11);
    rstn = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0); chk("arst_iv", int'(issue_valid), 0);
    chk("arst_ia", int'(in_allowin), 0); chk("arst_sw", int'(issue_swap), 0);
    mreset();
    eval(); adv();
    rstn = 1'b1;
    in_valid = 1'b0;

    // Randomized traffic.
    have = 0;
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      out_allowin = ($urandom_range(0, 3) != 0);
      wb_valid = 2'($urandom_range(0, 3)) & (($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00);
      wb_rd0 = 5'($urandom_range(0, 7));
      wb_rd1 = 5'($urandom_range(0, 7));
      if (!have && $urandom_range(0, 4) != 0) begin
        int r;
        inst_t x[2];
        for (int k = 0; k < 2; k++) begin
          x[k].rd = 5'($urandom_range(0, 7));
          x[k].rj = 5'($urandom_range(0, 7));
          x[k].rk = 5'($urandom_range(0, 7));
          x[k].we = 1'($urandom_range(0, 1));
          x[k].alu = 1'($urandom_range(0, 1));
          x[k].lng = !x[k].alu && ($urandom_range(0, 1) == 1);
          x[k].priv = ($urandom_range(0, 9) == 0);
        end
        r = int'($urandom_range(0, 5));
        go(x[0], x[1], (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b11);
        have = 1;
      end
      in_valid = have;
      eval();
      if (flush || e_ia) have = 0;
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
